// File: rtl/shift_register_4b_ctrl.sv
// rtl/shift_register_4b_ctrl.sv - shift/rotate/load register with an automatic serial transfer FSM
module shift_register_4b_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enb,
   input  logic             dir,
   input  logic [1:0]       modo,
   input  logic             s_in,
   input  logic [WIDTH-1:0] d,
   input  logic             start,
   output logic [WIDTH-1:0] q,
   output logic             s_out,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] XFER = 2'd1;
   localparam logic [1:0] FIN  = 2'd2;

   localparam logic [1:0] MODO_SHIFT = 2'b00;
   localparam logic [1:0] MODO_ROT   = 2'b01;
   localparam logic [1:0] MODO_LOAD  = 2'b10;

   localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] shift_q;
   logic             shift_out;

   // Plain serial shift, shared by IDLE shift mode and the transfer.
   always_comb begin
      shift_q   = q;
      shift_out = 1'b0;
      if (dir) begin
         shift_q   = {s_in, q[WIDTH-1:1]};
         shift_out = q[0];
      end else begin
         shift_q   = {q[WIDTH-2:0], s_in};
         shift_out = q[WIDTH-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         q     <= '0;
         s_out <= 1'b0;
      end else if (enb) begin
         case (state)
            IDLE: begin
               if (start) begin
                  q     <= d;
                  s_out <= 1'b0;
                  cnt   <= '0;
                  state <= XFER;
               end else begin
                  case (modo)
                     MODO_SHIFT: begin
                        q     <= shift_q;
                        s_out <= shift_out;
                     end
                     MODO_ROT: begin
                        q     <= dir ? {q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], q[WIDTH-1]};
                        s_out <= 1'b0;
                     end
                     MODO_LOAD: begin
                        q     <= d;
                        s_out <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
            XFER: begin
               q     <= shift_q;
               s_out <= shift_out;
               // The WIDTH-th shift closes the transfer and rearms the counter.
               if (cnt == LAST_SHIFT) begin
                  cnt   <= '0;
                  state <= FIN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            FIN: state <= IDLE;
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign busy = (state == XFER);
   assign done = (state == FIN);

endmodule

// File: tb/tb_shift_register_4b_ctrl.sv
// tb/tb_shift_register_4b_ctrl.sv - scoreboard bench for shift_register_4b_ctrl
module tb_shift_register_4b_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       enb;
   logic       dir;
   logic [1:0] modo;
   logic       s_in;
   logic [3:0] d;
   logic       start;
   logic [3:0] q;
   logic       s_out;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string      tag;
      logic [3:0] q;
      logic       s_out;
      logic       busy;
      logic       done;
   } exp_t;

   exp_t sb[$];

   shift_register_4b_ctrl #(.WIDTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .enb   (enb),
      .dir   (dir),
      .modo  (modo),
      .s_in  (s_in),
      .d     (d),
      .start (start),
      .q     (q),
      .s_out (s_out),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input logic [3:0] eq, input logic es,
                                input logic eb, input logic edn);
      check({tag, ".q"}, 32'(q), 32'(eq));
      check({tag, ".s_out"}, 32'(s_out), 32'(es));
      check({tag, ".busy"}, 32'(busy), 32'(eb));
      check({tag, ".done"}, 32'(done), 32'(edn));
   endtask

   // Drive one cycle of stimulus, queue its expected result, compare after the edge.
   task automatic step(input string tag, input logic e, input logic dr, input logic [1:0] m,
                       input logic si, input logic [3:0] dd, input logic st,
                       input logic [3:0] eq, input logic es, input logic eb, input logic edn);
      exp_t x;
      enb   = e;
      dir   = dr;
      modo  = m;
      s_in  = si;
      d     = dd;
      start = st;
      x.tag = tag; x.q = eq; x.s_out = es; x.busy = eb; x.done = edn;
      sb.push_back(x);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      check_outputs(x.tag, x.q, x.s_out, x.busy, x.done);
   endtask

   // Reset pulsed between edges must clear everything before the next edge.
   task automatic pulse_reset(input string tag);
      reset = 1'b1;
      #2;
      check_outputs(tag, 4'b0000, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; enb = 1'b0; dir = 1'b0; modo = 2'b11; s_in = 1'b0; d = 4'h0; start = 1'b0;
      #3;
      check_outputs("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // tag       enb dir modo  sin d      start  q        sout busy done
      step("load",  1, 0, 2'b10, 0, 4'b1011, 0,    4'b1011, 0,   0,   0);
      step("shl",   1, 0, 2'b00, 0, 4'b0000, 0,    4'b0110, 1,   0,   0);
      step("shr",   1, 1, 2'b00, 1, 4'b0000, 0,    4'b1011, 0,   0,   0);
      step("rotr1", 1, 1, 2'b01, 1, 4'b0000, 0,    4'b1101, 0,   0,   0);
      step("rotr2", 1, 1, 2'b01, 1, 4'b0000, 0,    4'b1110, 0,   0,   0);
      step("rotl",  1, 0, 2'b01, 1, 4'b0000, 0,    4'b1101, 0,   0,   0);
      step("shl1",  1, 0, 2'b00, 1, 4'b0000, 0,    4'b1011, 1,   0,   0);
      step("hold",  1, 0, 2'b11, 0, 4'b0000, 0,    4'b1011, 1,   0,   0);
      step("enb0",  0, 1, 2'b10, 0, 4'b0000, 1,    4'b1011, 1,   0,   0);

      // Full transfer; MODO/START toggled in XFER and START in FIN must be ignored.
      step("x.st",  1, 1, 2'b11, 0, 4'b1001, 1,    4'b1001, 0,   1,   0);
      step("x.s1",  1, 1, 2'b10, 0, 4'b1111, 1,    4'b0100, 1,   1,   0);
      step("x.s2",  1, 1, 2'b01, 0, 4'b1111, 0,    4'b0010, 0,   1,   0);
      step("x.s3",  1, 1, 2'b00, 0, 4'b1111, 0,    4'b0001, 0,   1,   0);
      step("x.s4",  1, 1, 2'b11, 0, 4'b1111, 0,    4'b0000, 1,   0,   1);
      step("x.fin", 1, 1, 2'b10, 0, 4'b1111, 1,    4'b0000, 1,   0,   0);
      step("x.idl", 1, 1, 2'b11, 0, 4'b1111, 0,    4'b0000, 1,   0,   0);

      // Same transfer stalled for two cycles after the second shift.
      step("st.st", 1, 1, 2'b11, 0, 4'b1001, 1,    4'b1001, 0,   1,   0);
      step("st.s1", 1, 1, 2'b11, 0, 4'b1001, 0,    4'b0100, 1,   1,   0);
      step("st.s2", 1, 1, 2'b11, 0, 4'b1001, 0,    4'b0010, 0,   1,   0);
      step("st.f1", 0, 0, 2'b10, 1, 4'b1111, 1,    4'b0010, 0,   1,   0);
      step("st.f2", 0, 0, 2'b00, 1, 4'b1111, 0,    4'b0010, 0,   1,   0);
      step("st.s3", 1, 1, 2'b11, 0, 4'b1001, 0,    4'b0001, 0,   1,   0);
      step("st.s4", 1, 1, 2'b11, 0, 4'b1001, 0,    4'b0000, 1,   0,   1);
      step("st.idl",1, 1, 2'b11, 0, 4'b1001, 0,    4'b0000, 1,   0,   0);

      // Async reset with Q=1111 while in XFER.
      step("r1.st", 1, 1, 2'b11, 0, 4'b1111, 1,    4'b1111, 0,   1,   0);
      pulse_reset("r1.rst");
      step("r1.idl",1, 0, 2'b11, 0, 4'b0000, 0,    4'b0000, 0,   0,   0);

      // Reset after two shifts (direction changed between them), then a fresh transfer.
      step("r2.st", 1, 0, 2'b11, 0, 4'b1111, 1,    4'b1111, 0,   1,   0);
      step("r2.s1", 1, 0, 2'b11, 0, 4'b1111, 0,    4'b1110, 1,   1,   0);
      step("r2.s2", 1, 1, 2'b11, 0, 4'b1111, 0,    4'b0111, 0,   1,   0);
      pulse_reset("r2.rst");
      step("r3.st", 1, 0, 2'b11, 1, 4'b0110, 1,    4'b0110, 0,   1,   0);
      step("r3.s1", 1, 0, 2'b11, 1, 4'b0110, 0,    4'b1101, 0,   1,   0);
      step("r3.s2", 1, 0, 2'b11, 0, 4'b0110, 0,    4'b1010, 1,   1,   0);
      step("r3.s3", 1, 1, 2'b11, 1, 4'b0110, 0,    4'b1101, 0,   1,   0);
      step("r3.s4", 1, 0, 2'b11, 0, 4'b0110, 0,    4'b1010, 1,   0,   1);
      step("r3.idl",1, 0, 2'b11, 0, 4'b0110, 0,    4'b1010, 1,   0,   0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/shift_register_4b_ctrl.md
SHIFT_REGISTER_4B_CTRL -- requirements
Module: shift_register_4b_ctrl

Interface
REQ-001 SHALL provide parameter: WIDTH, default 4, register width in bits; legal range WIDTH >= 2.
REQ-002 SHALL provide port: CLK  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide port: RESET  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port: ENB  input  1  enable; 0 freezes all state except reset.
REQ-005 SHALL provide port: DIR  input  1  shift direction; 0 = left (toward MSB), 1 = right (toward LSB).
REQ-006 SHALL provide port: MODO  input  2  operation in IDLE: 00 shift, 01 rotate, 10 parallel load, 11 hold.
REQ-007 SHALL provide port: S_IN  input  1  serial input bit, shifted into the vacated end.
REQ-008 SHALL provide port: D  input  WIDTH  parallel load data.
REQ-009 SHALL provide port: START  input  1  request an automatic WIDTH-bit serial transfer of D.
REQ-010 SHALL provide port: Q  output  WIDTH  register contents, registered.
REQ-011 SHALL provide port: S_OUT  output  1  bit shifted out on the last shift, registered.
REQ-012 SHALL provide port: BUSY  output  1  high while in XFER.
REQ-013 SHALL provide port: DONE  output  1  one-cycle pulse in FIN.

Function
REQ-014 SHALL implement three states: IDLE, XFER and FIN, with an internal shift counter of width clog2(WIDTH)+1.
REQ-015 SHALL freeze state, counter, Q and S_OUT on an edge with ENB=0 in any state.
REQ-016 In IDLE with ENB=1 and START=1, SHALL on that edge load Q<=D, clear S_OUT and counter, and enter XFER; START SHALL take priority over MODO.
REQ-017 In IDLE with ENB=1, START=0 and MODO=00, DIR=0, SHALL set Q<={Q[WIDTH-2:0],S_IN} and S_OUT<=Q[WIDTH-1].
REQ-018 In IDLE with ENB=1, START=0 and MODO=00, DIR=1, SHALL set Q<={S_IN,Q[WIDTH-1:1]} and S_OUT<=Q[0].
REQ-019 In IDLE with MODO=01, SHALL rotate: left Q<={Q[WIDTH-2:0],Q[WIDTH-1]}, right Q<={Q[0],Q[WIDTH-1:1]}; S_OUT<=0; S_IN ignored.
REQ-020 In IDLE with MODO=10, SHALL load Q<=D and S_OUT<=0; with MODO=11, SHALL hold Q and S_OUT.
REQ-021 In XFER with ENB=1, SHALL shift exactly as in REQ-017/REQ-018 per current DIR, ignoring MODO and START, and increment the counter.
REQ-022 In XFER, SHALL enter FIN on the edge where counter == WIDTH-1 (the WIDTH-th shift), leaving the counter at 0.
REQ-023 In FIN, SHALL hold Q and S_OUT, assert DONE=1 and BUSY=0, and return to IDLE on the next edge with ENB=1; START in FIN SHALL be ignored.
REQ-024 SHALL make BUSY and DONE decoded directly from state (Moore), never asserted together.
REQ-025 SHALL allow DIR changes mid-transfer, each shift using the DIR sampled on its own edge.

Reset
REQ-026 RESET=1 SHALL immediately, without a clock edge, force Q=0, S_OUT=0, BUSY=0, DONE=0, counter=0 and state IDLE, including mid-XFER or in FIN.
REQ-027 After RESET deasserts, the first rising edge SHALL perform normal IDLE operation.

Verification
REQ-028 Bench SHALL check async reset: Q=1111 in XFER, RESET pulsed between edges -> Q=0000, S_OUT=0, BUSY=0, DONE=0 before next edge.
REQ-029 Bench SHALL check load then shift: MODO=10, D=1011 -> Q=1011; then MODO=00, DIR=0, S_IN=0 -> Q=0110, S_OUT=1.
REQ-030 Bench SHALL check rotate: Q=1011, MODO=01, DIR=1 -> Q=1101, then Q=1110, with S_OUT=0.
REQ-031 Bench SHALL check transfer: START with D=1001, DIR=1, S_IN=0 -> BUSY high 4 cycles; S_OUT after shifts 1..4 = 1,0,0,1; final Q=0000; DONE high exactly 1 cycle.
REQ-032 Bench SHALL check stall: ENB=0 for 2 cycles after 2nd transfer shift -> Q and S_OUT frozen, DONE arrives 2 cycles later than in REQ-031.
REQ-033 Bench SHALL check reset mid-transfer: RESET after 2 shifts -> IDLE and Q=0000; new START with D=0110 completes a full 4-shift transfer.
